// File: rtl/uart_tx.sv
// uart_tx: UART transmitter paced by an external one-clock baud tick.
// Frame = start bit, 7 or 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx #(
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       send,
    input  logic [7:0] data,
    input  logic       size_flag,
    output logic       txd,
    output logic       run_flag,
    output logic       ready,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic       ODD_BIT   = (PARITY_ODD != 0);
    localparam logic       HAS_PAR   = (PARITY_EN != 0);

    state_t     state;
    logic [7:0] shifter;
    logic       size_q;
    logic       parity_acc;
    logic [3:0] bit_cnt;
    logic [3:0] data_last;

    // Index of the final data bit for the width latched at acceptance.
    assign data_last = size_q ? 4'd7 : 4'd6;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            txd        <= 1'b1;
            run_flag   <= 1'b0;
            ready      <= 1'b1;
            done       <= 1'b0;
            bit_cnt    <= 4'd0;
            shifter    <= 8'h00;
            size_q     <= 1'b0;
            parity_acc <= 1'b0;
        end else begin
            // NOTE: done defaults low every cycle so it can only ever be a single-cycle pulse.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (send) begin
                        shifter    <= data;
                        size_q     <= size_flag;
                        parity_acc <= 1'b0;
                        run_flag   <= 1'b1;
                        ready      <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (baud_tick) begin
                        state <= START;
                        txd   <= 1'b0;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        state      <= DATA;
                        bit_cnt    <= 4'd0;
                        txd        <= shifter[0];
                        parity_acc <= shifter[0];
                        shifter    <= {1'b0, shifter[7:1]};
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (bit_cnt == data_last) begin
                            if (HAS_PAR) begin
                                state <= PARITY;
                                txd   <= parity_acc ^ ODD_BIT;
                            end else begin
                                state   <= STOP;
                                txd     <= 1'b1;
                                bit_cnt <= 4'd0;
                            end
                        end else begin
                            bit_cnt    <= bit_cnt + 4'd1;
                            txd        <= shifter[0];
                            parity_acc <= parity_acc ^ shifter[0];
                            shifter    <= {1'b0, shifter[7:1]};
                        end
                    end
                end
                PARITY: begin
                    if (baud_tick) begin
                        state   <= STOP;
                        txd     <= 1'b1;
                        bit_cnt <= 4'd0;
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        if (bit_cnt == STOP_LAST) begin
                            state    <= IDLE;
                            done     <= 1'b1;
                            run_flag <= 1'b0;
                            ready    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    txd      <= 1'b1;
                    run_flag <= 1'b0;
                    ready    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: three parameterisations share one stimulus stream,
// each with its own frame-level reference model, expected-frame queue and line monitor.
module tb_uart_tx;

    localparam int N = 3;
    localparam int STOPS [N] = '{1, 2, 1};
    localparam int PEN   [N] = '{0, 1, 1};
    localparam int PODD  [N] = '{0, 0, 1};

    typedef struct {
        logic [15:0] bits;
        int          len;
        int          start;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       send = 1'b0;
    logic       size_flag = 1'b1;
    logic [7:0] data = 8'h00;
    logic       txd_v   [N];
    logic       run_v   [N];
    logic       ready_v [N];
    logic       done_v  [N];

    always #5 clk = ~clk;

    uart_tx #(.STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) u_d0 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .send(send), .data(data),
        .size_flag(size_flag), .txd(txd_v[0]), .run_flag(run_v[0]),
        .ready(ready_v[0]), .done(done_v[0]));
    uart_tx #(.STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(0)) u_d1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .send(send), .data(data),
        .size_flag(size_flag), .txd(txd_v[1]), .run_flag(run_v[1]),
        .ready(ready_v[1]), .done(done_v[1]));
    uart_tx #(.STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)) u_d2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .send(send), .data(data),
        .size_flag(size_flag), .txd(txd_v[2]), .run_flag(run_v[2]),
        .ready(ready_v[2]), .done(done_v[2]));

    int checks = 0;
    int errors = 0;

    task automatic check(string name, int i, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, i, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    frame_t expq [N][$];
    int     end_tick [N];
    int     expected_done [N];
    int     ticks = 0;
    int     phase = 15;
    bit     rand_ticks = 1'b0;

    function automatic frame_t make_frame(int i, logic [7:0] d, logic sz, int st);
        frame_t f;
        int     n;
        int     ones;
        n       = sz ? 8 : 7;
        ones    = 0;
        f.bits  = '1;
        f.bits[0] = 1'b0;
        f.start = st;
        for (int k = 0; k < n; k++) begin
            f.bits[1 + k] = d[k];
            if (d[k]) ones++;
        end
        f.len = 1 + n;
        if (PEN[i] == 1) begin
            f.bits[f.len] = logic'((ones % 2) == 1) ^ logic'(PODD[i] == 1);
            f.len++;
        end
        f.len += STOPS[i];
        return f;
    endfunction

    function automatic logic next_tick();
        if (phase == 0) begin
            phase = rand_ticks ? int'($urandom_range(1, 9)) : 15;
            return 1'b1;
        end
        phase--;
        return 1'b0;
    endfunction

    function automatic bit all_idle();
        for (int i = 0; i < N; i++)
            if (ticks < end_tick[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic cycle(logic t, logic s, logic [7:0] d, logic sz, logic r);
        frame_t f;
        @(negedge clk);
        baud_tick = t;
        send      = s;
        data      = d;
        size_flag = sz;
        rst       = r;
        for (int i = 0; i < N; i++) begin
            if (r) begin
                if (ticks < end_tick[i]) expected_done[i]--;
                end_tick[i] = ticks;
            end else if (s && ticks >= end_tick[i]) begin
                f = make_frame(i, d, sz, ticks + int'(t) + 1);
                end_tick[i] = f.start + f.len;
                expq[i].push_back(f);
                expected_done[i]++;
            end
        end
        ticks += int'(t);
    endtask

    task automatic step(logic s, logic [7:0] d, logic sz);
        cycle(next_tick(), s, d, sz, 1'b0);
    endtask

    task automatic send_frame(logic [7:0] d, logic sz, logic on_tick);
        while ((phase == 0) != on_tick) step(1'b0, 8'($urandom), 1'($urandom));
        step(1'b1, d, sz);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!all_idle() && n < 5000) begin
            step(1'b0, 8'($urandom), 1'($urandom));
            n++;
        end
        check("drain_timeout", 0, 32'(n < 5000), 32'd1);
        repeat (3) step(1'b0, 8'($urandom), 1'($urandom));
    endtask

    // ---------------- line monitor ----------------
    logic   edge_tick = 1'b0;
    logic   edge_rst  = 1'b1;
    int     mon_ticks = 0;
    frame_t cur [N];
    int     idx [N];
    bit     in_frame [N];
    logic   prev_txd [N];
    int     done_cnt [N];

    initial forever begin
        @(posedge clk);
        edge_tick = baud_tick;
        edge_rst  = rst;
    end

    task automatic mon_one(int i);
        if (edge_rst) begin
            check("rst_txd", i, 32'(txd_v[i]), 32'd1);
            check("rst_run", i, 32'(run_v[i]), 32'd0);
            check("rst_ready", i, 32'(ready_v[i]), 32'd1);
            check("rst_done", i, 32'(done_v[i]), 32'd0);
            in_frame[i] = 1'b0;
            expq[i].delete();
        end else if (!edge_tick) begin
            check("hold_txd", i, 32'(txd_v[i]), 32'(prev_txd[i]));
            check("hold_done", i, 32'(done_v[i]), 32'd0);
            if (in_frame[i]) check("busy_run", i, 32'(run_v[i]), 32'd1);
        end else if (!in_frame[i]) begin
            if (txd_v[i] == 1'b0) begin
                check("start_queued", i, 32'(expq[i].size() > 0), 32'd1);
                if (expq[i].size() > 0) begin
                    cur[i] = expq[i].pop_front();
                    check("start_tick", i, 32'(mon_ticks), 32'(cur[i].start));
                    check("start_run", i, 32'(run_v[i]), 32'd1);
                    check("start_ready", i, 32'(ready_v[i]), 32'd0);
                    idx[i]      = 1;
                    in_frame[i] = 1'b1;
                end
            end else begin
                check("idle_done", i, 32'(done_v[i]), 32'd0);
                if (expq[i].size() > 0)
                    check("late_start", i, 32'(mon_ticks < expq[i][0].start), 32'd1);
            end
        end else if (idx[i] < cur[i].len) begin
            check("bit", i, 32'(txd_v[i]), 32'(cur[i].bits[idx[i]]));
            check("bit_run", i, 32'(run_v[i]), 32'd1);
            check("bit_ready", i, 32'(ready_v[i]), 32'd0);
            check("bit_done", i, 32'(done_v[i]), 32'd0);
            idx[i]++;
        end else begin
            check("end_txd", i, 32'(txd_v[i]), 32'd1);
            check("end_done", i, 32'(done_v[i]), 32'd1);
            check("end_ready", i, 32'(ready_v[i]), 32'd1);
            check("end_run", i, 32'(run_v[i]), 32'd0);
            in_frame[i] = 1'b0;
            done_cnt[i]++;
        end
        prev_txd[i] = txd_v[i];
    endtask

    initial forever begin
        @(negedge clk);
        if (edge_tick) mon_ticks++;
        for (int i = 0; i < N; i++) mon_one(i);
    end

    // ---------------- stimulus ----------------
    int  s0;
    logic r_now;
    logic s_now;
    logic prev_r;

    initial begin
        for (int i = 0; i < N; i++) begin
            end_tick[i]      = 0;
            expected_done[i] = 0;
            done_cnt[i]      = 0;
            in_frame[i]      = 1'b0;
            idx[i]           = 0;
            prev_txd[i]      = 1'b1;
        end
        repeat (3) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        repeat (2) step(1'b0, 8'h00, 1'b1);

        // Directed frames at a fixed 16-clock bit time; size_flag and data
        // are randomised every cycle while busy.
        send_frame(8'hA5, 1'b1, 1'b0);
        drain();
        send_frame(8'hFF, 1'b0, 1'b0);
        drain();
        send_frame(8'h03, 1'b1, 1'b0);
        drain();
        send_frame(8'h96, 1'b1, 1'b1);
        drain();

        // Continuous send: only acceptance-time requests start frames.
        repeat (400) step(1'b1, 8'($urandom), 1'($urandom));
        drain();

        // Reset while the first instance is on data[3].
        send_frame(8'h5A, 1'b1, 1'b0);
        s0 = end_tick[0] - 10;
        while (ticks < s0 + 4) step(1'b0, 8'($urandom), 1'($urandom));
        repeat (3) step(1'b0, 8'($urandom), 1'($urandom));
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        repeat (2) step(1'b0, 8'h00, 1'b1);
        send_frame(8'hC3, 1'b1, 1'b0);
        drain();

        // Random tick spacing, sends and occasional resets.
        rand_ticks = 1'b1;
        prev_r     = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            r_now = logic'($urandom_range(0, 599) == 0);
            s_now = !prev_r && !r_now && ($urandom_range(0, 5) == 0);
            if (r_now) cycle(1'b0, 1'b0, 8'($urandom), 1'($urandom), 1'b1);
            else       step(s_now, 8'($urandom), 1'($urandom));
            prev_r = r_now;
        end
        repeat (2) step(1'b0, 8'h00, 1'b1);
        drain();

        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            check("queue_empty", i, 32'(expq[i].size()), 32'd0);
            check("frames_done", i, 32'(done_cnt[i]), 32'(expected_done[i]));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
